matched_result_reader: RTL and testbench



---
 rtl/sift_match_pkg.sv | 47 ++++
 rtl/match_out_fifo.sv | 62 ++++++
 rtl/matched_result_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_matched_result_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_match_pkg.sv
// -----------------------------------------------------------------------------
// sift_match_pkg
// Shared definitions for the matched-result read-out path.
//   - Geometry of the matched-result banks (record width, depth, address width,
//     bank count) and the width of the per-bank record counts.
//   - Record field layout: bit REC_W-1 is the match-valid flag and bits
//     [REC_W-2:0] carry the payload.
//   - Reader FSM state enum (IDLE/SCAN/DRAIN/FIN).
//   - Layout of one output-buffer entry {data, bank, index}.
// -----------------------------------------------------------------------------
package sift_match_pkg;

    localparam int REC_W     = 47;
    localparam int DEPTH     = 512;
    localparam int ADDR_W    = 9;
    localparam int NBANK     = 4;
    localparam int BANK_W    = 2;
    localparam int CNT_W     = 10;   // holds 0..DEPTH inclusive
    localparam int FLAG_BIT  = REC_W - 1;
    localparam int PAYLOAD_W = REC_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic                 flag;
        logic [PAYLOAD_W-1:0] payload;
    } match_rec_t;

    typedef struct packed {
        logic [REC_W-1:0]  data;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] index;
    } out_entry_t;

    localparam int ENTRY_W = $bits(out_entry_t);

    // A bank never holds more than DEPTH records; larger counts saturate.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
    endfunction

endpackage

// File: rtl/match_out_fifo.sv
// -----------------------------------------------------------------------------
// match_out_fifo
// Small synchronous FIFO buffering read-back records ahead of the output port.
// The head entry is visible combinationally whenever the FIFO is not empty.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   flush        empties the FIFO (pointers and count cleared)
//   push         write push_data at the tail
//   push_data    WIDTH-bit entry
//   pop          remove the head entry (caller guarantees !empty)
//   head         current head entry
//   count        current occupancy, 0..DEPTH_F
//   empty        occupancy is zero
// -----------------------------------------------------------------------------
module match_out_fifo #(
    parameter int  DEPTH_F = 2,
    parameter int  WIDTH   = 58,
    localparam int PTR_W   = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1,
    localparam int FCNT_W  = $clog2(DEPTH_F + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic [FCNT_W-1:0] count,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH_F];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [FCNT_W-1:0] count_q;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_F - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count_q <= count_q + FCNT_W'(push) - FCNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/matched_result_reader.sv
// -----------------------------------------------------------------------------
// matched_result_reader
// Drains the four matched-result banks after matching completes and streams
// every stored record out as {data, bank, index}, bank 0 index 0 first,
// ascending index, then ascending bank.
//
// Build option: define MATCH_SKIP_INVALID_EN to drop records whose flag bit
// (REC_W-1) is 0. Dropped records still consume their read slot, so index
// sequencing and out_index values are unchanged.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle pulse, honoured only in IDLE
//   bank_count_0..3    records held per bank (clamped to 512), latched on start
//   mem_addr           registered address driven onto every bank's addr2 port
//   mem_dout_0..3      bank read data, valid MEM_LAT cycles after mem_addr
//   out_valid/ready    output handshake: a record transfers on a clock edge
//                      where out_valid && out_ready; while out_valid is high
//                      and out_ready low, out_data/out_bank/out_index hold
//   out_data/bank/index  record at the head of the output buffer (0 when idle)
//   busy               high from the cycle after start until the FSM is idle
//   done               one-cycle pulse the cycle after the final transfer
//   dbg_state          current FSM state
// -----------------------------------------------------------------------------
module matched_result_reader
    import sift_match_pkg::*;
#(
    parameter int FIFO_D  = 2,   // must be >= MEM_LAT+1 for full throughput
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  bank_count_0,
    input  logic [CNT_W-1:0]  bank_count_1,
    input  logic [CNT_W-1:0]  bank_count_2,
    input  logic [CNT_W-1:0]  bank_count_3,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [REC_W-1:0]  mem_dout_0,
    input  logic [REC_W-1:0]  mem_dout_1,
    input  logic [REC_W-1:0]  mem_dout_2,
    input  logic [REC_W-1:0]  mem_dout_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REC_W-1:0]  out_data,
    output logic [BANK_W-1:0] out_bank,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam int FCNT_W = $clog2(FIFO_D + 1);
    localparam int OCC_W  = $clog2(FIFO_D + MEM_LAT + 1) + 1;
    localparam int BSEL_W = BANK_W + 1;   // one extra value marks "past bank 3"
    localparam int LAST   = MEM_LAT - 1;

    state_t state, state_nx;

    logic [CNT_W-1:0]  cnt_q [NBANK];
    logic [BSEL_W-1:0] bank_q;
    logic [ADDR_W-1:0] idx_q;

    logic [MEM_LAT-1:0] tag_v;
    logic [BANK_W-1:0]  tag_bank [MEM_LAT];
    logic [ADDR_W-1:0]  tag_idx  [MEM_LAT];

    logic              cur_found;
    logic [BANK_W-1:0] cur_bank;
    logic              idx_last;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic              can_issue;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_flush;
    logic [FCNT_W-1:0] fifo_count;
    out_entry_t        push_entry;
    out_entry_t        head_entry;
    logic [REC_W-1:0]  ret_data;

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = SCAN;
            SCAN:  if (!cur_found) state_nx = DRAIN;
            // Leave DRAIN on the edge that empties the buffer so that done
            // lands in the cycle right after the final transfer.
            DRAIN: if ((tag_v == '0) &&
                       ((fifo_count == '0) ||
                        ((fifo_count == FCNT_W'(1)) && fifo_pop)))
                       state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        dbg_state = state;
    end

    // --------------------------------------------------------- read issue --
    // First bank at or after bank_q that still has records; empty banks are
    // skipped within a single cycle.
    always_comb begin
        cur_found = 1'b0;
        cur_bank  = '0;
        for (int b = NBANK - 1; b >= 0; b--) begin
            if ((BSEL_W'(b) >= bank_q) && (cnt_q[b] != '0)) begin
                cur_found = 1'b1;
                cur_bank  = BANK_W'(b);
            end
        end
    end

    assign idx_last = ({1'b0, idx_q} == (cnt_q[cur_bank] - CNT_W'(1)));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + OCC_W'(tag_v[i]);
    end

    // Credit check: buffer slots after this cycle's pop, plus every read that
    // will still land, must leave room for one more.
    assign occ       = OCC_W'(fifo_count) + inflight - OCC_W'(fifo_pop);
    assign can_issue = (state == SCAN) && cur_found && (occ < OCC_W'(FIFO_D));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NBANK; k++) cnt_q[k] <= '0;
            bank_q   <= '0;
            idx_q    <= '0;
            mem_addr <= '0;
            tag_v    <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                cnt_q[0] <= clamp_count(bank_count_0);
                cnt_q[1] <= clamp_count(bank_count_1);
                cnt_q[2] <= clamp_count(bank_count_2);
                cnt_q[3] <= clamp_count(bank_count_3);
                bank_q   <= '0;
                idx_q    <= '0;
            end
            if (can_issue) begin
                mem_addr <= idx_q;
                if (idx_last) begin
                    idx_q  <= '0;
                    bank_q <= BSEL_W'(cur_bank) + BSEL_W'(1);
                end else begin
                    idx_q <= idx_q + ADDR_W'(1);
                end
            end
            tag_v[0] <= can_issue;
            for (int i = 1; i < MEM_LAT; i++) tag_v[i] <= tag_v[i-1];
        end
    end

    // Tag payload travels alongside tag_v; only the valid bits need reset.
    always_ff @(posedge clk) begin
        tag_bank[0] <= cur_bank;
        tag_idx[0]  <= idx_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_bank[i] <= tag_bank[i-1];
            tag_idx[i]  <= tag_idx[i-1];
        end
    end

    // -------------------------------------------------------- return path --
    // Select read data by the bank that issued the read, not the bank the
    // scanner is on now.
    always_comb begin
        case (tag_bank[LAST])
            2'd0:    ret_data = mem_dout_0;
            2'd1:    ret_data = mem_dout_1;
            2'd2:    ret_data = mem_dout_2;
            default: ret_data = mem_dout_3;
        endcase
    end

    assign push_entry = '{data: ret_data, bank: tag_bank[LAST], index: tag_idx[LAST]};

`ifdef MATCH_SKIP_INVALID_EN
    match_rec_t ret_rec;
    assign ret_rec   = match_rec_t'(ret_data);
    assign fifo_push = tag_v[LAST] && ret_rec.flag;
`else
    assign fifo_push = tag_v[LAST];
`endif

    assign fifo_flush = (state == IDLE) && start;
    assign fifo_pop   = out_valid && out_ready;

    match_out_fifo #(
        .DEPTH_F (FIFO_D),
        .WIDTH   (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------ output --
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head_entry.data  : '0;
    assign out_bank  = out_valid ? head_entry.bank  : '0;
    assign out_index = out_valid ? head_entry.index : '0;

endmodule

// File: tb/tb_matched_result_reader.sv
// -----------------------------------------------------------------------------
// tb_matched_result_reader
// Bench for matched_result_reader. Bank contents are random; the expected
// record stream is derived from the bank arrays and the counts alone.
// The bank model is an array read addressed by the registered mem_addr, so
// data is valid one cycle after the read is issued (MEM_LAT = 1).
// -----------------------------------------------------------------------------
module tb_matched_result_reader;
    import sift_match_pkg::*;

    localparam int RW = REC_W + BANK_W + ADDR_W;

    // ------------------------------------------------- clock / reset / DUT --
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  bank_count_0 = '0;
    logic [CNT_W-1:0]  bank_count_1 = '0;
    logic [CNT_W-1:0]  bank_count_2 = '0;
    logic [CNT_W-1:0]  bank_count_3 = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [REC_W-1:0]  mem_dout_0, mem_dout_1, mem_dout_2, mem_dout_3;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [REC_W-1:0]  out_data;
    logic [BANK_W-1:0] out_bank;
    logic [ADDR_W-1:0] out_index;
    logic              busy, done;
    state_t            dbg_state;

    logic [REC_W-1:0]  bank_mem [NBANK][DEPTH];

    always #5 clk = ~clk;

    assign mem_dout_0 = bank_mem[0][mem_addr];
    assign mem_dout_1 = bank_mem[1][mem_addr];
    assign mem_dout_2 = bank_mem[2][mem_addr];
    assign mem_dout_3 = bank_mem[3][mem_addr];

    matched_result_reader #(.FIFO_D(2), .MEM_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bank_count_0 (bank_count_0),
        .bank_count_1 (bank_count_1),
        .bank_count_2 (bank_count_2),
        .bank_count_3 (bank_count_3),
        .mem_addr     (mem_addr),
        .mem_dout_0   (mem_dout_0),
        .mem_dout_1   (mem_dout_1),
        .mem_dout_2   (mem_dout_2),
        .mem_dout_3   (mem_dout_3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bank     (out_bank),
        .out_index    (out_index),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // ------------------------------------------------------ bookkeeping --
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [RW-1:0] exp_q[$];
    logic          tail_kept = 1'b0;

    int hs_cnt = 0, valid_cnt = 0, done_cnt = 0, addr_nz = 0;
    int first_hs_cyc = -1, last_hs_cyc = -1, done_cyc = -1, first_valid_cyc = -1;
    logic          stall_prev = 1'b0;
    logic [RW-1:0] held = '0;
    int ready_mode = 0;
    int rpat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endfunction

    // ------------------------------------------------------ ready driver --
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
                rpat++;
            end
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------------------------------------------------- monitor --
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_addr != '0) addr_nz++;
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (stall_prev)
                check("stall_hold", {out_valid, out_data, out_bank, out_index}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_record actual=%0h/%0d/%0d required=none (cycle %0d)",
                             out_data, out_bank, out_index, cyc);
                end else begin
                    check("record", {out_data, out_bank, out_index}, exp_q.pop_front());
                end
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_data, out_bank, out_index};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ------------------------------------------------ reference model --
    // Every stored record in bank order, then index order.
    task automatic build_expected(input int c0, input int c1, input int c2, input int c3);
        int cnts[NBANK] = '{c0, c1, c2, c3};
        exp_q.delete();
        tail_kept = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            int n;
            n = (cnts[b] > DEPTH) ? DEPTH : cnts[b];
            for (int i = 0; i < n; i++) begin
                logic [REC_W-1:0] rec;
                logic keep;
                rec  = bank_mem[b][i];
                keep = 1'b1;
`ifdef MATCH_SKIP_INVALID_EN
                keep = rec[REC_W-1];
`endif
                tail_kept = keep;
                if (keep) exp_q.push_back({rec, BANK_W'(b), ADDR_W'(i)});
            end
        end
    endtask

    // ---------------------------------------------------- driver tasks --
    task automatic fill_banks(input logic force_flag);
        for (int b = 0; b < NBANK; b++)
            for (int i = 0; i < DEPTH; i++) begin
                bank_mem[b][i] = REC_W'({$urandom, $urandom});
                if (force_flag) bank_mem[b][i][REC_W-1] = 1'b1;
            end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; valid_cnt = 0; done_cnt = 0; addr_nz = 0;
        first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic pulse_start(input int c0, input int c1, input int c2, input int c3,
                               input int rmode, output int s);
        @(posedge clk); #1;
        ready_mode = rmode;
        rpat = 0;
        clear_stats();
        bank_count_0 = CNT_W'(c0);
        bank_count_1 = CNT_W'(c1);
        bank_count_2 = CNT_W'(c2);
        bank_count_3 = CNT_W'(c3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic run_case(input string tag, input int c0, input int c1, input int c2,
                            input int c3, input int rmode, output int s, output int n_exp);
        int budget;
        build_expected(c0, c1, c2, c3);
        n_exp  = exp_q.size();
        budget = 4 * (c0 + c1 + c2 + c3) + 50;
        pulse_start(c0, c1, c2, c3, rmode, s);
        check({tag, "_busy_after_start"}, busy, 1);
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            @(negedge clk); #1;
        end
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_records"}, hs_cnt, n_exp);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_after_done"}, busy, 0);
        if (n_exp > 0 && tail_kept)
            check({tag, "_done_after_last_hs"}, done_cyc, last_hs_cyc + 1);
    endtask

    // ------------------------------------------------------------ tests --
    initial begin
        int s, n;
        fill_banks(1'b1);

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bank", out_bank, 0);
        check("rst_out_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // All counts zero
        run_case("t2", 0, 0, 0, 0, 0, s, n);
        check("t2_no_valid", valid_cnt, 0);
        check("t2_done_latency", done_cyc, s + 2);
        check("t2_mem_addr_still", addr_nz, 0);

        // Sparse counts, order and first-record latency
        run_case("t1", 3, 0, 2, 1, 0, s, n);
        check("t1_first_valid_latency", first_valid_cyc, s + 2);

        // Full banks, back-to-back
        run_case("t3", 512, 512, 512, 512, 0, s, n);
        check("t3_first_valid_latency", first_valid_cyc, s + 2);
        check("t3_no_bubbles", last_hs_cyc - first_hs_cyc, 2047);

        // Back-pressure 1,0,0,1
        run_case("t4", 5, 0, 0, 0, 1, s, n);

        // Reset in the middle of bank 1
        build_expected(3, 50, 0, 0);
        pulse_start(3, 50, 0, 0, 0, s);
        for (int k = 0; k < 200 && !(out_valid && out_bank == 2'd1); k++) @(negedge clk);
        check("t5_reached_bank1", out_bank, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_outputs", {out_valid, out_data, out_bank, out_index, done, mem_addr}, 0);
        check("t5_rst_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        run_case("t5b", 1, 0, 0, 0, 0, s, n);
        check("t5b_one_record", hs_cnt, 1);

        // Flag pattern 1,0,1,0 in bank 0
        for (int i = 0; i < 4; i++) bank_mem[0][i][REC_W-1] = ((i % 2) == 0);
        run_case("t6", 4, 0, 0, 0, 2, s, n);

        // Count above 512 saturates
        fill_banks(1'b1);
        run_case("clamp", 0, 0, 0, 700, 0, s, n);
        check("clamp_count", hs_cnt, 512);

        // Random counts, random flags, random back-pressure
        fill_banks(1'b0);
        for (int r = 0; r < 4; r++) begin
            run_case("rand", $urandom_range(0, 40), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 40), 2, s, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
